// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage core datapath and pipe_hazard_ctrl.
// The master side (datapath) drives register IDs, decode info and the memory
// handshake. The slave side (hazard controller) returns stall/flush and
// forwarding controls.
interface pipe_hazard_ctrl_if;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic [4:0] rs1_e;
  logic [4:0] rs2_e;
  logic [4:0] rd_e;
  logic [4:0] rd_m;
  logic [4:0] rd_w;
  logic [1:0] result_src_e;
  logic       reg_write_m;
  logic       reg_write_w;
  logic       pc_src_e;
  logic       mem_req_m;
  logic       mem_ready;
  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       stall_m;
  logic       flush_d;
  logic       flush_e;
  logic       flush_w;
  logic [1:0] forward_a_e;
  logic [1:0] forward_b_e;
  logic       mem_err;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output result_src_e, reg_write_m, reg_write_w, pc_src_e,
    output mem_req_m, mem_ready,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_w,
    input  forward_a_e, forward_b_e, mem_err
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  result_src_e, reg_write_m, reg_write_w, pc_src_e,
    input  mem_req_m, mem_ready,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_w,
    output forward_a_e, forward_b_e, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Handles load-use stalls, taken-branch flushes and E-stage operand forwarding.
// It also holds the whole pipeline while an M-stage memory access waits for
// mem_ready. A hold is abandoned once the wait budget of MEM_TIMEOUT cycles is
// used up, and mem_err then pulses for one cycle.
// Optional feature macro: PERF_CNT_EN adds saturating performance counters
// (cnt_lw_stall, cnt_flush, cnt_mem_wait, CNT_W bits each).
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   hz
`ifdef PERF_CNT_EN
  , output logic [CNT_W-1:0]  cnt_lw_stall
  , output logic [CNT_W-1:0]  cnt_flush
  , output logic [CNT_W-1:0]  cnt_mem_wait
`endif
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_nxt;
  logic              err_nxt;
  logic              mem_err_q;
  logic              mem_stall;
  logic              lw_stall;
  logic              timeout;

  // Load-use hazard: the load in E writes a register that the instruction in D reads.
  always_comb begin
    lw_stall = (hz.result_src_e == 2'b01) && (hz.rd_e != 5'd0) &&
               ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
    timeout  = (wcnt == WCNT_LAST);
  end

  // State register and error pulse. Reset drops any memory wait at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wcnt      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      mem_err_q <= err_nxt;
    end
  end

  // Memory-wait FSM. The first unacknowledged cycle in RUN is already held,
  // so the hold length is capped at MEM_TIMEOUT-1 cycles. A stall is never
  // raised while reset is high.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    err_nxt   = 1'b0;
    mem_stall = 1'b0;
    case (state)
      RUN: begin
        if (hz.mem_req_m && !hz.mem_ready) begin
          mem_stall = !rst;
          state_nxt = MEM_WAIT;
          wcnt_nxt  = WCNT_ONE;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end else if (timeout) begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
          err_nxt   = 1'b1;
        end else begin
          mem_stall = !rst;
          wcnt_nxt  = wcnt + WCNT_ONE;
        end
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = '0;
      end
    endcase
  end

  // Stall/flush outputs. A memory hold freezes everything and defers other hazards.
  // A taken branch overrides a load-use stall.
  always_comb begin
    if (mem_stall) begin
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
      hz.stall_e = 1'b1;
      hz.stall_m = 1'b1;
      hz.flush_d = 1'b0;
      hz.flush_e = 1'b0;
      hz.flush_w = 1'b1;
    end else begin
      hz.stall_f = lw_stall && !hz.pc_src_e;
      hz.stall_d = lw_stall && !hz.pc_src_e;
      hz.stall_e = 1'b0;
      hz.stall_m = 1'b0;
      hz.flush_d = hz.pc_src_e;
      hz.flush_e = lw_stall || hz.pc_src_e;
      hz.flush_w = 1'b0;
    end
    hz.mem_err = mem_err_q;
  end

  // Operand forwarding for the E-stage ALU. The younger M result wins over W.
  always_comb begin
    hz.forward_a_e = 2'b00;
    hz.forward_b_e = 2'b00;
    if (hz.reg_write_m && (hz.rd_m != 5'd0) && (hz.rd_m == hz.rs1_e)) begin
      hz.forward_a_e = 2'b10;
    end else if (hz.reg_write_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs1_e)) begin
      hz.forward_a_e = 2'b01;
    end
    if (hz.reg_write_m && (hz.rd_m != 5'd0) && (hz.rd_m == hz.rs2_e)) begin
      hz.forward_b_e = 2'b10;
    end else if (hz.reg_write_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs2_e)) begin
      hz.forward_b_e = 2'b01;
    end
  end

`ifdef PERF_CNT_EN
  // Saturating event counters for load-use stalls, branch flushes and memory-hold cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_lw_stall <= '0;
      cnt_flush    <= '0;
      cnt_mem_wait <= '0;
    end else begin
      if (lw_stall && !mem_stall && (cnt_lw_stall != '1)) begin
        cnt_lw_stall <= cnt_lw_stall + 1'b1;
      end
      if (hz.pc_src_e && !mem_stall && (cnt_flush != '1)) begin
        cnt_flush <= cnt_flush + 1'b1;
      end
      if (mem_stall && (cnt_mem_wait != '1)) begin
        cnt_mem_wait <= cnt_mem_wait + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4).
// A reference model treats each memory access as a budget of held cycles.
// One negedge process compares every DUT output against that model. Directed
// scenarios with literal expectations come first, then randomized traffic.
module tb_pipe_hazard_ctrl;
  localparam int T = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if hz_if ();

`ifdef PERF_CNT_EN
  logic [31:0] cnt_lw_stall;
  logic [31:0] cnt_flush;
  logic [31:0] cnt_mem_wait;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .hz           (hz_if)
`ifdef PERF_CNT_EN
    , .cnt_lw_stall (cnt_lw_stall)
    , .cnt_flush    (cnt_flush)
    , .cnt_mem_wait (cnt_mem_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(
    input logic [4:0] rs1_d, input logic [4:0] rs2_d,
    input logic [4:0] rs1_e, input logic [4:0] rs2_e,
    input logic [4:0] rd_e, input logic [4:0] rd_m, input logic [4:0] rd_w,
    input logic [1:0] result_src_e, input logic reg_write_m, input logic reg_write_w,
    input logic pc_src_e, input logic mem_req_m, input logic mem_ready);
    hz_if.rs1_d        = rs1_d;
    hz_if.rs2_d        = rs2_d;
    hz_if.rs1_e        = rs1_e;
    hz_if.rs2_e        = rs2_e;
    hz_if.rd_e         = rd_e;
    hz_if.rd_m         = rd_m;
    hz_if.rd_w         = rd_w;
    hz_if.result_src_e = result_src_e;
    hz_if.reg_write_m  = reg_write_m;
    hz_if.reg_write_w  = reg_write_w;
    hz_if.pc_src_e     = pc_src_e;
    hz_if.mem_req_m    = mem_req_m;
    hz_if.mem_ready    = mem_ready;
  endtask

  task automatic applyMem(input logic req, input logic ready);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, req, ready);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Forwarding rule from the register IDs alone.
  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (hz_if.reg_write_m && hz_if.rd_m != 0 && hz_if.rd_m == rs) return 2'b10;
    if (hz_if.reg_write_w && hz_if.rd_w != 0 && hz_if.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Reference model: an outstanding access has used m_held cycles of its hold budget.
  bit          m_waiting;
  int          m_held;
  bit          m_err_now;
  longint      m_cnt_lw;
  longint      m_cnt_fl;
  longint      m_cnt_mw;

  always @(negedge clk) begin
    bit         lw;
    bit         ms;
    logic [6:0] exp_ctrl;
    lw = (hz_if.result_src_e == 2'b01) && (hz_if.rd_e != 0) &&
         ((hz_if.rd_e == hz_if.rs1_d) || (hz_if.rd_e == hz_if.rs2_d));
    if (rst) ms = 0;
    else if (!m_waiting) ms = hz_if.mem_req_m && !hz_if.mem_ready;
    else ms = !hz_if.mem_ready && (m_held < T - 1);

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
    if (ms) exp_ctrl = 7'b1111001;
    else exp_ctrl = {lw && !hz_if.pc_src_e, lw && !hz_if.pc_src_e, 2'b00,
                     hz_if.pc_src_e, lw || hz_if.pc_src_e, 1'b0};

    checkOutput("ctrl", {25'd0, hz_if.stall_f, hz_if.stall_d, hz_if.stall_e, hz_if.stall_m,
                hz_if.flush_d, hz_if.flush_e, hz_if.flush_w}, {25'd0, exp_ctrl});
    checkOutput("forward_a_e", {30'd0, hz_if.forward_a_e}, {30'd0, fwd_model(hz_if.rs1_e)});
    checkOutput("forward_b_e", {30'd0, hz_if.forward_b_e}, {30'd0, fwd_model(hz_if.rs2_e)});
    checkOutput("mem_err", {31'd0, hz_if.mem_err}, {31'd0, (m_err_now && !rst)});
`ifdef PERF_CNT_EN
    checkOutput("cnt_lw_stall", cnt_lw_stall, rst ? 32'd0 : 32'(m_cnt_lw));
    checkOutput("cnt_flush", cnt_flush, rst ? 32'd0 : 32'(m_cnt_fl));
    checkOutput("cnt_mem_wait", cnt_mem_wait, rst ? 32'd0 : 32'(m_cnt_mw));
`endif

    if (rst) begin
      m_waiting = 0;
      m_held    = 0;
      m_err_now = 0;
      m_cnt_lw  = 0;
      m_cnt_fl  = 0;
      m_cnt_mw  = 0;
    end else begin
      if (lw && !ms) m_cnt_lw++;
      if (hz_if.pc_src_e && !ms) m_cnt_fl++;
      if (ms) m_cnt_mw++;
      m_err_now = m_waiting && !hz_if.mem_ready && (m_held == T - 1);
      if (!m_waiting) begin
        if (hz_if.mem_req_m && !hz_if.mem_ready) begin
          m_waiting = 1;
          m_held    = 1;
        end
      end else if (hz_if.mem_ready || m_held == T - 1) begin
        m_waiting = 0;
        m_held    = 0;
      end else begin
        m_held++;
      end
    end
  end

  initial begin
    int ready_pct;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    applyMem(0, 0);
    #2;
    checkOutput("reset_stall_f", {31'd0, hz_if.stall_f}, 32'd0);
    checkOutput("reset_mem_err", {31'd0, hz_if.mem_err}, 32'd0);
    step();
    step();
    rst = 1'b0;

    // Load-use: lw x5 in E, D reads x5.
    step();
    applyStimulus(5, 0, 0, 0, 5, 0, 0, 2'b01, 0, 0, 0, 0, 0);
    #1;
    checkOutput("lw_stall_f", {31'd0, hz_if.stall_f}, 32'd1);
    checkOutput("lw_stall_d", {31'd0, hz_if.stall_d}, 32'd1);
    checkOutput("lw_flush_e", {31'd0, hz_if.flush_e}, 32'd1);
    checkOutput("lw_flush_d", {31'd0, hz_if.flush_d}, 32'd0);
    step();
    applyStimulus(5, 0, 0, 0, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    #1;
    checkOutput("lw_released", {31'd0, hz_if.stall_f}, 32'd0);

    // Branch and load-use together: branch wins.
    step();
    applyStimulus(5, 0, 0, 0, 5, 0, 0, 2'b01, 0, 0, 1, 0, 0);
    #1;
    checkOutput("br_stall_f", {31'd0, hz_if.stall_f}, 32'd0);
    checkOutput("br_flush_d", {31'd0, hz_if.flush_d}, 32'd1);
    checkOutput("br_flush_e", {31'd0, hz_if.flush_e}, 32'd1);

    // Forwarding priority and x0.
    step();
    applyStimulus(0, 0, 3, 7, 0, 3, 3, 2'b00, 1, 1, 0, 0, 0);
    #1;
    checkOutput("fwd_m_wins", {30'd0, hz_if.forward_a_e}, 32'd2);
    applyStimulus(0, 0, 3, 7, 0, 2, 7, 2'b00, 1, 1, 0, 0, 0);
    #1;
    checkOutput("fwd_w", {30'd0, hz_if.forward_b_e}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0);
    #1;
    checkOutput("fwd_x0", {30'd0, hz_if.forward_a_e}, 32'd0);

    // Memory acknowledged after 3 held cycles.
    step();
    applyMem(1, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      checkOutput("mw_stall_m", {31'd0, hz_if.stall_m}, 32'd1);
      checkOutput("mw_flush_w", {31'd0, hz_if.flush_w}, 32'd1);
    end
    step();
    applyMem(1, 1);
    #1;
    checkOutput("mw_ready_release", {31'd0, hz_if.stall_f}, 32'd0);
    step();
    applyMem(0, 0);
    #1;
    checkOutput("mw_no_err", {31'd0, hz_if.mem_err}, 32'd0);

    // Timeout: memory never answers.
    step();
    applyMem(1, 0);
    for (int i = 0; i < T - 1; i++) begin
      if (i > 0) step();
      #1;
      checkOutput("to_stall", {31'd0, hz_if.stall_e}, 32'd1);
    end
    step();
    #1;
    checkOutput("to_release", {31'd0, hz_if.stall_e}, 32'd0);
    checkOutput("to_err_not_yet", {31'd0, hz_if.mem_err}, 32'd0);
    step();
    applyMem(0, 0);
    #1;
    checkOutput("to_err_pulse", {31'd0, hz_if.mem_err}, 32'd1);
    step();
    #1;
    checkOutput("to_err_clear", {31'd0, hz_if.mem_err}, 32'd0);

    // Reset in the middle of a wait, then a fresh full-length hold.
    step();
    applyMem(1, 0);
    step();
    step();
    #1;
    checkOutput("rst_pre_stall", {31'd0, hz_if.stall_f}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_stall_drop", {31'd0, hz_if.stall_f}, 32'd0);
    checkOutput("rst_flush_w_drop", {31'd0, hz_if.flush_w}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < T - 1; i++) begin
      if (i > 0) step();
      #1;
      checkOutput("rst_fresh_hold", {31'd0, hz_if.stall_d}, 32'd1);
    end
    step();
    #1;
    checkOutput("rst_fresh_release", {31'd0, hz_if.stall_d}, 32'd0);
    step();
    applyMem(0, 0);
    #1;
    checkOutput("rst_fresh_err", {31'd0, hz_if.mem_err}, 32'd1);

    // Randomized traffic in phases of differing memory latency.
    for (int phase = 0; phase < 6; phase++) begin
      ready_pct = (phase % 3 == 0) ? 5 : ((phase % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 150; c++) begin
        step();
        rst = ($urandom_range(0, 199) == 0);
        applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 99) < ready_pct));
      end
    end
    step();
    rst = 1'b0;
    applyMem(0, 0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
